nxn_xbar_allocator: RTL and testbench
=====================================

# nxn_xbar_allocator

Sequential control end of the single NxN crossbar. It arbitrates among PORT_N input buffers whose head flits request an output port, and locks a winner for a whole wormhole packet. While locked it drives the crossbar's `in_sel`/`out_sel` selectors and produces the per-cycle transfer handshake, which pops the input buffer and strobes the output. It sits in the switch between the input FIFOs/route computation and the crossbar datapath, one instance per switch.

## Interface
Parameters:
- `PORT_N`, default 5: number of input and output ports.
- `SEL_W`, default `$clog2(PORT_N)`: selector width. Derived; do not override.

Ports:
- `clk_i`, input, 1: single clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `req_valid_i`, input, PORT_N: bit n set when input n holds a head flit.
- `req_dest_i`, input, PORT_N*SEL_W: requested output of input n, at slice `[n*SEL_W +: SEL_W]`.
- `req_last_i`, input, PORT_N: head flit of input n is a packet tail.
- `out_ready_i`, input, PORT_N: output n can accept a flit this cycle.
- `in_sel_o`, output, SEL_W: crossbar input selector, registered.
- `out_sel_o`, output, SEL_W: crossbar output selector, registered.
- `xfer_o`, output, 1: a flit crosses the crossbar this cycle.
- `in_pop_o`, output, PORT_N: one-hot pop to the granted input buffer, qualified by `xfer_o`.
- `out_valid_o`, output, PORT_N: one-hot valid to the granted output, qualified by `xfer_o`.
- `busy_o`, output, 1: the allocator is locked to a packet.

## Operation
- There are two states. IDLE: no lock. BUSY: locked to the pair (`in_sel_o`, `out_sel_o`).
- **IDLE:**
  - Eligible inputs are those with `req_valid_i[n]=1` and `req_dest_i[n] < PORT_N`.
  - Round-robin search starts at `rr_ptr` and proceeds in increasing index order, wrapping from PORT_N-1 to 0.
  - On a winner w: register `in_sel_o=w` and `out_sel_o=req_dest_i[w]`, then go to BUSY.
  - With no eligible input, stay in IDLE.
  - Out-of-range destinations are never granted and never popped.
- **BUSY:**
  - Transfer condition: `xfer = req_valid_i[in_sel_o] & out_ready_i[out_sel_o]`. It is combinational.
  - When the transfer condition holds, in the same cycle: `in_pop_o[in_sel_o]=1`, `out_valid_o[out_sel_o]=1`, `xfer_o=1`.
  - A transfer with `req_last_i[in_sel_o]=1` completes the packet. At the next edge: state goes to IDLE and `rr_ptr` becomes `(in_sel_o+1) mod PORT_N`.
  - Without `last`, stay in BUSY.
  - `req_dest_i` and other inputs' requests are ignored while BUSY; the destination is latched.
  - Valid dropping mid-packet (a bubble) means no transfer; the lock is held.
- The granted input may equal the destination index (U-turn); this is allowed.
- Only one packet is in flight at a time, matching the single-path crossbar.
- Outside BUSY, `xfer_o`, `in_pop_o` and `out_valid_o` are 0. `busy_o=1` exactly in BUSY.

## Timing
- Reset values: state IDLE, `rr_ptr=0`, `in_sel_o=0`, `out_sel_o=0`, `xfer_o=0`, `in_pop_o=0`, `out_valid_o=0`, `busy_o=0`.
- Grant latency: request seen in IDLE at cycle t → BUSY and selectors valid at t+1 → earliest `xfer_o` at t+1.
- Tail transfer at cycle k → IDLE at k+1 → next grant BUSY at k+2. This is a fixed one-cycle bubble between packets.
- A single-flit packet occupies 2 cycles minimum: the IDLE arbitration cycle plus one BUSY transfer cycle.
- Asserting `rst_i` mid-packet immediately forces IDLE, clears all outputs and sets `rr_ptr=0`. The partial packet is not completed.
- `out_ready_i` low holds BUSY with no pops for any number of cycles.

## Structure
- Shared package/header `xbar_pkg` holds:
  - the state encoding localparams (`ST_IDLE`, `ST_BUSY`);
  - the `SEL_W` derivation helper, also reused by `nxn_single_crossbar`.
- Sub-module `rr_arbiter` is purely combinational:
  - inputs: PORT_N requests and a pointer;
  - outputs: a one-hot grant and its encoded index, plus an `any_gnt` flag.
- The top-level instance holds the state register, `rr_ptr` and the selector registers.

## Test plan
All scenarios use PORT_N=5.
- **Reset:**
  - Assert `rst_i` with random inputs → all outputs 0 and `busy_o=0`.
  - Deassert → first grant searches from input 0.
- **Single-flit packet:** `req_valid_i=5'b00100`, dest[2]=3, last[2]=1, `out_ready_i=5'b11111` →
  - next cycle: `in_sel_o=2`, `out_sel_o=3`, `xfer_o=1`, `in_pop_o=5'b00100`, `out_valid_o=5'b01000`;
  - IDLE the cycle after.
- **Round-robin fairness:** inputs 0, 1 and 4 continuously request single-flit packets → grant order 0, 1, 4, 0, 1 …, with one idle cycle between grants.
- **Wormhole lock:**
  - Input 1 sends a 4-flit packet to output 0; input 3 requests mid-packet.
  - Required: input 3 is not granted until after the tail of input 1.
  - A dest change on input 1 mid-packet has no effect.
- **Backpressure and bubbles:**
  - Deassert `out_ready_i[0]` for 3 cycles mid-packet, then drop `req_valid_i[1]` for 2 cycles.
  - Required: `xfer_o=0` and no pops throughout, `busy_o=1`, and the transfer resumes.
- **Illegal dest and reset mid-packet:**
  - dest=7 on input 2 → never granted.
  - Asserting `rst_i` during BUSY → IDLE on the same cycle; after release, `rr_ptr=0`.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared definitions for the single NxN crossbar: allocator state encoding and
// the selector-width helper used by the allocator and nxn_single_crossbar.
package xbar_pkg;

  // Allocator lock state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Selector width for n ports, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr_i and walks
// upward, wrapping from PORT_N-1 to 0.
//   req_i     : per-port request
//   ptr_i     : highest-priority index
//   gnt_o     : one-hot grant
//   gnt_idx_o : encoded grant index
//   any_gnt_o : a grant was issued
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned PORT_N = 5,
  parameter int unsigned SEL_W  = sel_width(PORT_N)
) (
  input  logic [PORT_N-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [PORT_N-1:0] gnt_o,
  output logic [SEL_W-1:0]  gnt_idx_o,
  output logic              any_gnt_o
);

  logic [SEL_W-1:0] idx;

  // First requester at or after ptr_i, in modulo order.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < PORT_N; i++) begin
      idx = SEL_W'((32'(ptr_i) + i) % PORT_N);
      if (!any_gnt_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        any_gnt_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nxn_xbar_allocator.sv
// Wormhole allocator for a single-path NxN crossbar. In IDLE it round-robin
// arbitrates among inputs with a legal head-flit destination; in BUSY it holds
// the (input, output) pair until a tail flit transfers.
//   clk_i, rst_i : clock, async active-high reset
//   req_valid_i  : head flit present per input
//   req_dest_i   : requested output per input, SEL_W bits each
//   req_last_i   : head flit is a packet tail
//   out_ready_i  : output can accept a flit
//   in_sel_o     : registered crossbar input selector
//   out_sel_o    : registered crossbar output selector
//   xfer_o       : flit crosses this cycle (combinational in BUSY)
//   in_pop_o     : one-hot pop to the locked input, qualified by xfer_o
//   out_valid_o  : one-hot strobe to the locked output, qualified by xfer_o
//   busy_o       : locked to a packet
module nxn_xbar_allocator
  import xbar_pkg::*;
#(
  parameter int unsigned PORT_N = 5,
  parameter int unsigned SEL_W  = sel_width(PORT_N)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PORT_N-1:0]         req_valid_i,
  input  logic [PORT_N*SEL_W-1:0]   req_dest_i,
  input  logic [PORT_N-1:0]         req_last_i,
  input  logic [PORT_N-1:0]         out_ready_i,
  output logic [SEL_W-1:0]          in_sel_o,
  output logic [SEL_W-1:0]          out_sel_o,
  output logic                      xfer_o,
  output logic [PORT_N-1:0]         in_pop_o,
  output logic [PORT_N-1:0]         out_valid_o,
  output logic                      busy_o
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] in_sel_q, in_sel_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [SEL_W-1:0]  dest_a [PORT_N];
  logic [PORT_N-1:0] elig_c;
  logic [PORT_N-1:0] gnt_c;
  logic [SEL_W-1:0]  gnt_idx_c;
  logic              any_gnt_c;
  logic              xfer_c;

  // Unpack destinations; out-of-range destinations are never eligible.
  // The compare is one bit wider so PORT_N itself is representable.
  always_comb begin
    for (int unsigned n = 0; n < PORT_N; n++) begin
      dest_a[n] = req_dest_i[n*SEL_W +: SEL_W];
      elig_c[n] = req_valid_i[n] && ({1'b0, dest_a[n]} < (SEL_W+1)'(PORT_N));
    end
  end

  rr_arbiter #(
    .PORT_N (PORT_N),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req_i     (elig_c),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_c),
    .gnt_idx_o (gnt_idx_c),
    .any_gnt_o (any_gnt_c)
  );

  // Transfer handshake on the locked pair.
  assign xfer_c = (state_q == ST_BUSY) && req_valid_i[in_sel_q] && out_ready_i[out_sel_q];

  // Next-state: grant in IDLE, release on tail transfer in BUSY.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    in_sel_d  = in_sel_q;
    out_sel_d = out_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (any_gnt_c) begin
          state_d  = ST_BUSY;
          in_sel_d = gnt_idx_c;
          for (int unsigned n = 0; n < PORT_N; n++) begin
            if (gnt_c[n]) begin
              out_sel_d = dest_a[n];
            end
          end
        end
      end
      ST_BUSY: begin
        if (xfer_c && req_last_i[in_sel_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (in_sel_q == SEL_W'(PORT_N - 1)) ? '0 : in_sel_q + SEL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
    end
  end

  assign in_sel_o    = in_sel_q;
  assign out_sel_o   = out_sel_q;
  assign busy_o      = (state_q == ST_BUSY);
  assign xfer_o      = xfer_c;
  assign in_pop_o    = xfer_c ? (PORT_N'(1) << in_sel_q)  : '0;
  assign out_valid_o = xfer_c ? (PORT_N'(1) << out_sel_q) : '0;

endmodule

// File: tb/tb_nxn_xbar_allocator.sv
// Directed bench for nxn_xbar_allocator with PORT_N=5: a per-cycle vector
// table plus hand-written reset sequences.
module tb_nxn_xbar_allocator;

  localparam int unsigned PN = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned NV = 38;

  logic          clk;
  logic          rst;
  logic [PN-1:0] valid;
  logic [PN*SW-1:0] dest;
  logic [PN-1:0] last;
  logic [PN-1:0] ready;
  logic [SW-1:0] in_sel;
  logic [SW-1:0] out_sel;
  logic          xfer;
  logic [PN-1:0] pop;
  logic [PN-1:0] oval;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          rst;
    logic [4:0]    valid;
    logic [14:0]   dest;
    logic [4:0]    last;
    logic [4:0]    ready;
    logic          busy;
    logic [2:0]    in_sel;
    logic [2:0]    out_sel;
    logic          xfer;
    logic [4:0]    pop;
    logic [4:0]    oval;
    logic          chk_sel;
  } vec_t;

  vec_t tbl [NV];

  nxn_xbar_allocator #(.PORT_N(PN)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_dest_i  (dest),
    .req_last_i  (last),
    .out_ready_i (ready),
    .in_sel_o    (in_sel),
    .out_sel_o   (out_sel),
    .xfer_o      (xfer),
    .in_pop_o    (pop),
    .out_valid_o (oval),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] dp(input logic [2:0] d0, input logic [2:0] d1,
                                     input logic [2:0] d2, input logic [2:0] d3,
                                     input logic [2:0] d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  function automatic vec_t v(input logic r, input logic [4:0] vl, input logic [14:0] ds,
                             input logic [4:0] ls, input logic [4:0] rd, input logic b,
                             input logic [2:0] is, input logic [2:0] os, input logic x,
                             input logic [4:0] p, input logic [4:0] o, input logic cs);
    vec_t t;
    t.rst = r; t.valid = vl; t.dest = ds; t.last = ls; t.ready = rd;
    t.busy = b; t.in_sel = is; t.out_sel = os; t.xfer = x; t.pop = p; t.oval = o;
    t.chk_sel = cs;
    return t;
  endfunction

  // Vector with the allocator expected idle before the edge.
  function automatic vec_t vi(input logic [4:0] vl, input logic [14:0] ds,
                              input logic [4:0] ls, input logic [4:0] rd);
    return v(1'b0, vl, ds, ls, rd, 1'b0, 3'd0, 3'd0, 1'b0, 5'b0, 5'b0, 1'b0);
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  initial begin
    // Reset with every input asserted, then first grant from input 0.
    tbl[0]  = v(1'b1, 5'b11111, dp(1,1,1,1,1), 5'b11111, 5'b11111, 1'b0, 3'd0, 3'd0, 1'b0, 5'b0, 5'b0, 1'b1);
    tbl[1]  = vi(5'b11111, dp(1,1,1,1,1), 5'b11111, 5'b11111);
    tbl[2]  = v(1'b0, 5'b11111, dp(1,1,1,1,1), 5'b11111, 5'b11111, 1'b1, 3'd0, 3'd1, 1'b1, 5'b00001, 5'b00010, 1'b0);
    // Single-flit packet input 2 -> output 3.
    tbl[3]  = vi(5'b00100, dp(0,0,3,0,0), 5'b00100, 5'b11111);
    tbl[4]  = v(1'b0, 5'b00100, dp(0,0,3,0,0), 5'b00100, 5'b11111, 1'b1, 3'd2, 3'd3, 1'b1, 5'b00100, 5'b01000, 1'b0);
    tbl[5]  = vi(5'b00000, dp(0,0,0,0,0), 5'b00000, 5'b11111);
    // Round-robin among 0, 1, 4 starting from pointer 3.
    tbl[6]  = vi(5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111);
    tbl[7]  = v(1'b0, 5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111, 1'b1, 3'd4, 3'd2, 1'b1, 5'b10000, 5'b00100, 1'b0);
    tbl[8]  = vi(5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111);
    tbl[9]  = v(1'b0, 5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111, 1'b1, 3'd0, 3'd2, 1'b1, 5'b00001, 5'b00100, 1'b0);
    tbl[10] = vi(5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111);
    tbl[11] = v(1'b0, 5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111, 1'b1, 3'd1, 3'd2, 1'b1, 5'b00010, 5'b00100, 1'b0);
    tbl[12] = vi(5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111);
    tbl[13] = v(1'b0, 5'b10011, dp(2,2,0,0,2), 5'b10011, 5'b11111, 1'b1, 3'd4, 3'd2, 1'b1, 5'b10000, 5'b00100, 1'b0);
    tbl[14] = vi(5'b00000, dp(0,0,0,0,0), 5'b00000, 5'b11111);
    // Wormhole: input 1 four flits to output 0; input 3 competes; dest change ignored.
    tbl[15] = vi(5'b00010, dp(0,0,0,0,0), 5'b00000, 5'b11111);
    tbl[16] = v(1'b0, 5'b01010, dp(0,0,0,2,0), 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd0, 1'b1, 5'b00010, 5'b00001, 1'b0);
    tbl[17] = v(1'b0, 5'b01010, dp(0,4,0,2,0), 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd0, 1'b1, 5'b00010, 5'b00001, 1'b0);
    // Backpressure on output 0 for three cycles.
    tbl[18] = v(1'b0, 5'b01010, dp(0,4,0,2,0), 5'b00000, 5'b11110, 1'b1, 3'd1, 3'd0, 1'b0, 5'b0, 5'b0, 1'b0);
    tbl[19] = v(1'b0, 5'b01010, dp(0,4,0,2,0), 5'b00000, 5'b11110, 1'b1, 3'd1, 3'd0, 1'b0, 5'b0, 5'b0, 1'b0);
    tbl[20] = v(1'b0, 5'b01010, dp(0,4,0,2,0), 5'b00000, 5'b11110, 1'b1, 3'd1, 3'd0, 1'b0, 5'b0, 5'b0, 1'b0);
    // Bubble: input 1 valid drops for two cycles.
    tbl[21] = v(1'b0, 5'b01000, dp(0,4,0,2,0), 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd0, 1'b0, 5'b0, 5'b0, 1'b0);
    tbl[22] = v(1'b0, 5'b01000, dp(0,4,0,2,0), 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd0, 1'b0, 5'b0, 5'b0, 1'b0);
    tbl[23] = v(1'b0, 5'b01010, dp(0,0,0,2,0), 5'b00000, 5'b11111, 1'b1, 3'd1, 3'd0, 1'b1, 5'b00010, 5'b00001, 1'b0);
    tbl[24] = v(1'b0, 5'b01010, dp(0,0,0,2,0), 5'b00010, 5'b11111, 1'b1, 3'd1, 3'd0, 1'b1, 5'b00010, 5'b00001, 1'b0);
    // Input 3 only after the tail, after one idle cycle.
    tbl[25] = vi(5'b01000, dp(0,0,0,2,0), 5'b01000, 5'b11111);
    tbl[26] = v(1'b0, 5'b01000, dp(0,0,0,2,0), 5'b01000, 5'b11111, 1'b1, 3'd3, 3'd2, 1'b1, 5'b01000, 5'b00100, 1'b0);
    tbl[27] = vi(5'b00000, dp(0,0,0,0,0), 5'b00000, 5'b11111);
    // Illegal destination 7 on input 2 is never granted.
    tbl[28] = vi(5'b00100, dp(0,0,7,0,0), 5'b00100, 5'b11111);
    tbl[29] = vi(5'b00100, dp(0,0,7,0,0), 5'b00100, 5'b11111);
    tbl[30] = vi(5'b00100, dp(0,0,7,0,0), 5'b00100, 5'b11111);
    tbl[31] = vi(5'b00101, dp(1,0,7,0,0), 5'b00101, 5'b11111);
    tbl[32] = v(1'b0, 5'b00101, dp(1,0,7,0,0), 5'b00101, 5'b11111, 1'b1, 3'd0, 3'd1, 1'b1, 5'b00001, 5'b00010, 1'b0);
    tbl[33] = vi(5'b00100, dp(0,0,7,0,0), 5'b00100, 5'b11111);
    tbl[34] = vi(5'b00100, dp(0,0,7,0,0), 5'b00100, 5'b11111);
    // U-turn: input 3 to output 3.
    tbl[35] = vi(5'b01000, dp(0,0,0,3,0), 5'b01000, 5'b11111);
    tbl[36] = v(1'b0, 5'b01000, dp(0,0,0,3,0), 5'b01000, 5'b11111, 1'b1, 3'd3, 3'd3, 1'b1, 5'b01000, 5'b01000, 1'b0);
    tbl[37] = vi(5'b00000, dp(0,0,0,0,0), 5'b00000, 5'b11111);

    rst = 1'b1; valid = '0; dest = '0; last = '0; ready = '0;
    @(negedge clk);

    for (int i = 0; i < int'(NV); i++) begin
      rst = tbl[i].rst; valid = tbl[i].valid; dest = tbl[i].dest;
      last = tbl[i].last; ready = tbl[i].ready;
      #2;
      chk("busy", i, 32'(busy), 32'(tbl[i].busy));
      chk("xfer", i, 32'(xfer), 32'(tbl[i].xfer));
      chk("in_pop", i, 32'(pop), 32'(tbl[i].pop));
      chk("out_valid", i, 32'(oval), 32'(tbl[i].oval));
      if (tbl[i].busy || tbl[i].chk_sel) begin
        chk("in_sel", i, 32'(in_sel), 32'(tbl[i].in_sel));
        chk("out_sel", i, 32'(out_sel), 32'(tbl[i].out_sel));
      end
      @(negedge clk);
    end

    // Reset mid-packet: pointer is 4 here, so input 1 wins from 4,0,1.
    valid = 5'b00010; dest = dp(0,4,0,0,0); last = 5'b00000; ready = 5'b11111;
    @(negedge clk);
    #2;
    chk("pre_rst_busy", 100, 32'(busy), 32'd1);
    chk("pre_rst_in_sel", 100, 32'(in_sel), 32'd1);
    chk("pre_rst_xfer", 100, 32'(xfer), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 101, 32'(busy), 32'd0);
    chk("rst_xfer", 101, 32'(xfer), 32'd0);
    chk("rst_pop", 101, 32'(pop), 32'd0);
    chk("rst_oval", 101, 32'(oval), 32'd0);
    chk("rst_in_sel", 101, 32'(in_sel), 32'd0);
    chk("rst_out_sel", 101, 32'(out_sel), 32'd0);
    @(negedge clk);
    // Pointer back at 0: inputs 1 and 4 compete, input 1 must win.
    rst = 1'b0; valid = 5'b10010; dest = dp(0,2,0,0,2); last = 5'b10010;
    #2;
    chk("post_rst_idle", 102, 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    chk("post_rst_busy", 103, 32'(busy), 32'd1);
    chk("post_rst_in_sel", 103, 32'(in_sel), 32'd1);
    chk("post_rst_out_sel", 103, 32'(out_sel), 32'd2);
    chk("post_rst_pop", 103, 32'(pop), 32'b00010);
    @(negedge clk);

    // Reset held with random inputs keeps every output at zero.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid = 5'($urandom); dest = 15'($urandom); last = 5'($urandom); ready = 5'($urandom);
      #2;
      chk("rnd_rst_busy", 200 + i, 32'(busy), 32'd0);
      chk("rnd_rst_xfer", 200 + i, 32'(xfer), 32'd0);
      chk("rnd_rst_pop", 200 + i, 32'(pop), 32'd0);
      chk("rnd_rst_oval", 200 + i, 32'(oval), 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
